lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer placed between the execute stage (ALU result, rs_2, func_3, op_type) and the data-memory bus.
- For op_type=1 instructions: stalls the pipeline, runs a req/ack memory transaction, aligns and extends read data, then presents one writeback.
- For op_type=0 instructions: registers the ALU result straight through to writeback.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for i_mem_ack before the transaction is aborted as a bus error (legal range 2..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute-stage result valid this cycle
- i_op_type  in  1  1 = memory op, 0 = ALU op
- i_opcode  in  7  LOAD (0000011) or STORE (0100011) when i_op_type=1
- i_func_3  in  3  access size/sign
- i_alu_out  in  32  effective address (memory op) or result (ALU op)
- i_rs_2  in  32  store data
- i_rd_num  in  5  destination register
- o_stall  out  1  hold upstream stages
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- i_mem_ack  in  1  bus acknowledge; read data valid in the same cycle
- i_mem_rdata  in  32  bus read data
- wb_valid  out  1  writeback strobe, one cycle
- wb_rd_num  out  5  writeback register
- wb_data  out  32  writeback value
- o_bus_err  out  1  one-cycle pulse on timeout
- o_misalign  out  1  one-cycle pulse on a misaligned access (see Optional Feature)

Behaviour:
- Reset (async, immediate): state=IDLE; every output is 0, including mem_req dropping mid-transaction; wait counter=0.
- Reset mid-transaction: the transaction is abandoned; no writeback and no error pulse are issued.
- FSM states: IDLE, REQ, DONE.
- IDLE, i_valid & i_op_type=0:
  - Next edge: wb_valid=(i_rd_num!=0), wb_rd_num=i_rd_num, wb_data=i_alu_out.
  - Latency 1; no stall.
- IDLE, i_valid & i_op_type=1:
  - o_stall=1 combinationally in this cycle.
  - Latch opcode, func_3, address, rs_2 and rd.
  - Next state REQ; wb_valid=0.
- REQ:
  - mem_req=1 and o_stall=1.
  - mem_addr, mem_we, mem_be and mem_wdata are held constant from the latched values for the whole state.
  - Wait counter increments every cycle without ack.
  - Ack seen → DONE; the load result is captured on that same edge.
  - Counter reaches TIMEOUT-1 with no ack → DONE flagged as error.
- DONE (exactly one cycle):
  - mem_req=0 and o_stall=0.
  - Inputs are ignored: they still carry the instruction just serviced.
  - Load with rd!=0 and no error: wb_valid=1 with the formatted data.
  - Store: no writeback.
  - Error: o_bus_err=1, no writeback.
  - Next state IDLE.
- Size encoding (func_3): 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 are treated as word.
- Store lanes:
  - SB: be=0001<<a[1:0], wdata={4{rs_2[7:0]}}.
  - SH: be=0011<<{a[1],1'b0}, wdata={2{rs_2[15:0]}}.
  - SW: be=1111, wdata=rs_2.
  - Loads drive be=1111 and mem_we=0.
- Load formatting:
  - Select byte a[1:0] or half a[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned access: half with a[0]=1, or word with a[1:0]!=0.
- Total memory-op latency: 1 (accept) + n (wait for ack, n≥1) + 1 (DONE).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned access issues no bus request: IDLE→DONE directly.
  - o_misalign pulses in DONE; no writeback.
- Undefined:
  - Low address bits are forced to natural alignment (half: a[0]=0; word: a[1:0]=0) and the access proceeds normally.
  - o_misalign is tied 0.

Test Plan:
- ALU op: i_valid=1, op_type=0, rd=5, alu_out=0x1234 → next cycle wb_valid=1, rd 5, data 0x1234, o_stall never 1.
- LB from address 0x103, ack after 3 cycles, rdata=0x80FFFFFF → mem_addr=0x100, be=1111; wb_data=0xFFFFFF80; LBU on the same data → 0x00000080; stall lasts until the DONE cycle.
- SH at 0x202, rs_2=0xABCD1234 → mem_we=1, be=1100, wdata=0x12341234, addr=0x200; no wb_valid.
- Never ack, TIMEOUT=16 → mem_req high for exactly 16 cycles, o_bus_err pulses once, no writeback, returns to IDLE.
- LW at 0x305:
  - Macro defined: no mem_req, o_misalign pulse.
  - Macro undefined: addr=0x304, normal writeback.
- rst_n low during REQ → mem_req, o_stall and wb_valid go to 0 immediately; after release an ALU op writes back normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute stage and data-memory bus.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic        i_op_type,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_func_3,
  input  logic [31:0] i_alu_out,
  input  logic [31:0] i_rs_2,
  input  logic [4:0]  i_rd_num,
  output logic        o_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd_num,
  output logic [31:0] wb_data,
  output logic        o_bus_err,
  output logic        o_misalign
);

  localparam int unsigned CNT_W   = 8;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        addr_q, wdata_q;
  logic [3:0]         be_q;
  logic [1:0]         off_q;
  logic [2:0]         f3_q;
  logic               st_q;
  logic [4:0]         rd_q;

  logic               accept, in_byte, in_half, in_store, timeout;
  logic [1:0]         in_off;
  logic [3:0]         in_be;
  logic [31:0]        in_wdata, load_fmt;
  logic [7:0]         byte_sel;
  logic [15:0]        half_sel;

  logic               wb_valid_d, bus_err_d;
  logic [4:0]         wb_rd_d;
  logic [31:0]        wb_data_d;

  assign accept   = (state == IDLE) & i_valid & i_op_type;
  assign in_byte  = (i_func_3[1:0] == 2'b00);
  assign in_half  = (i_func_3[1:0] == 2'b01);
  assign in_store = (i_opcode == OP_STORE);
  assign timeout  = (cnt == CNT_W'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic in_mis, misalign_d;
  assign in_mis = (in_half & i_alu_out[0]) | (~in_byte & ~in_half & (|i_alu_out[1:0]));
`endif

  // Natural alignment of the low address bits, then store lane placement
  always_comb begin
    in_off   = i_alu_out[1:0];
    in_be    = 4'b1111;
    in_wdata = i_rs_2;
    if (in_half)       in_off[0] = 1'b0;
    else if (!in_byte) in_off    = 2'b00;
    if (in_store) begin
      if (in_byte) begin
        in_be    = 4'b0001 << in_off;
        in_wdata = {4{i_rs_2[7:0]}};
      end else if (in_half) begin
        in_be    = 4'b0011 << {in_off[1], 1'b0};
        in_wdata = {2{i_rs_2[15:0]}};
      end
    end
  end

  // Lane select and sign/zero extension of read data
  always_comb begin
    byte_sel = i_mem_rdata[{off_q, 3'b000} +: 8];
    half_sel = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_fmt = {{24{~f3_q[2] & byte_sel[7]}}, byte_sel};
      2'b01:   load_fmt = {{16{~f3_q[2] & half_sel[15]}}, half_sel};
      default: load_fmt = i_mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
          state_nxt = in_mis ? DONE : REQ;
`else
          state_nxt = REQ;
`endif
        end
      end
      REQ:     if (i_mem_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive, stall, and next values of the registered writeback/status outputs
  always_comb begin
    mem_req    = (state == REQ);
    mem_we     = mem_req & st_q;
    mem_addr   = mem_req ? addr_q : 32'd0;
    mem_be     = mem_req ? be_q : 4'd0;
    mem_wdata  = mem_req ? wdata_q : 32'd0;
    o_stall    = mem_req | accept;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_num;
    wb_data_d  = wb_data;
    bus_err_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = accept & in_mis;
`endif
    if (state == IDLE && i_valid && !i_op_type) begin
      wb_valid_d = (i_rd_num != 5'd0);
      wb_rd_d    = i_rd_num;
      wb_data_d  = i_alu_out;
    end else if (state == REQ) begin
      if (i_mem_ack) begin
        wb_valid_d = ~st_q & (rd_q != 5'd0);
        wb_rd_d    = rd_q;
        wb_data_d  = load_fmt;
      end else if (timeout) begin
        bus_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      st_q      <= 1'b0;
      rd_q      <= '0;
      wb_valid  <= 1'b0;
      wb_rd_num <= '0;
      wb_data   <= '0;
      o_bus_err <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= {i_alu_out[31:2], 2'b00};
        wdata_q <= in_wdata;
        be_q    <= in_be;
        off_q   <= in_off;
        f3_q    <= i_func_3;
        st_q    <= in_store;
        rd_q    <= i_rd_num;
      end
      cnt       <= (state == REQ && !i_mem_ack) ? cnt + CNT_W'(1) : '0;
      wb_valid  <= wb_valid_d;
      wb_rd_num <= wb_rd_d;
      wb_data   <= wb_data_d;
      o_bus_err <= bus_err_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_misalign <= 1'b0;
    else        o_misalign <= misalign_d;
  end
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: randomized load/store/ALU traffic against
// an arithmetic reference model, with a bus responder and an output monitor.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_op_type;
  logic [6:0]  i_opcode;
  logic [2:0]  i_func_3;
  logic [31:0] i_alu_out, i_rs_2;
  logic [4:0]  i_rd_num;
  logic        o_stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_num;
  logic [31:0] wb_data;
  logic        o_bus_err, o_misalign;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_op_type(i_op_type),
    .i_opcode(i_opcode), .i_func_3(i_func_3), .i_alu_out(i_alu_out),
    .i_rs_2(i_rs_2), .i_rd_num(i_rd_num), .o_stall(o_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .wb_valid(wb_valid), .wb_rd_num(wb_rd_num),
    .wb_data(wb_data), .o_bus_err(o_bus_err), .o_misalign(o_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          d;
    logic [31:0] rdata;
    int          len;
  } bus_t;

  // kind: 0 writeback, 1 bus error, 2 misalign
  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
  } ev_t;

  bus_t bus_q[$];
  ev_t  ev_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    int    size;
    longint v, span;
    size = acc_size(f3);
    span = longint'(1) << (8 * size);
    v = (longint'(rdata) >> (8 * off)) % span;
    if (f3[2] == 1'b0 && size < 4 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // Bus responder: checks every request cycle and acks after the planned delay
  initial begin : responder
    bus_t cur;
    bit   active = 0;
    int   k = 0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'd0;
    cur.addr = 0; cur.we = 0; cur.be = 0; cur.wdata = 0; cur.d = 0; cur.rdata = 0; cur.len = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active = 0;
        i_mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!active) begin
          if (bus_q.size() == 0) begin
            chk("unexpected_req", 32'd1, 32'd0);
            cur.addr = 0; cur.we = 0; cur.be = 0; cur.wdata = 0; cur.d = 0; cur.len = 1;
          end else begin
            cur = bus_q.pop_front();
          end
          active = 1;
          k = 0;
        end
        chk("bus_addr", mem_addr, cur.addr);
        chk("bus_we", 32'(mem_we), 32'(cur.we));
        chk("bus_be", 32'(mem_be), 32'(cur.be));
        if (cur.we) chk("bus_wdata", mem_wdata, cur.wdata);
        if (k == cur.d) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = cur.rdata;
        end else begin
          i_mem_ack   = 1'b0;
          i_mem_rdata = $urandom;
        end
        k++;
      end else begin
        if (active) chk("req_len", 32'(k), 32'(cur.len));
        active = 0;
        i_mem_ack = 1'b0;
      end
    end
  end

  // Output monitor: pops one expected event per strobe
  initial begin : monitor
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rst_n && (wb_valid || o_bus_err || o_misalign)) begin
        chk("single_strobe", 32'(int'(wb_valid) + int'(o_bus_err) + int'(o_misalign)), 32'd1);
        kind = wb_valid ? 0 : (o_bus_err ? 1 : 2);
        if (ev_q.size() == 0) begin
          chk("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = ev_q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          if (kind == 0 && e.kind == 0) begin
            chk("wb_rd_num", 32'(wb_rd_num), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
          end
        end
      end
    end
  end

  // Drive one instruction at a negedge, hold it through the stall, return at the next free negedge
  task automatic issue(input logic mem, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] rs2, input logic [4:0] rd,
                       input int d, input logic [31:0] rdata);
    int   size, off, len, cnt, exp_stall;
    bit   mis, trap;
    logic [31:0] aligned, wd;
    logic [3:0]  be;
    bus_t b;
    ev_t  e;
    i_valid   = 1'b1;
    i_op_type = mem;
    i_opcode  = mem ? (st ? OP_STORE : OP_LOAD) : 7'($urandom);
    i_func_3  = f3;
    i_alu_out = a;
    i_rs_2    = rs2;
    i_rd_num  = rd;
    if (!mem) begin
      if (rd != 5'd0) begin
        e.kind = 0; e.rd = rd; e.data = a;
        ev_q.push_back(e);
      end
      #1 chk("alu_no_stall", 32'(o_stall), 32'd0);
      @(negedge clk);
    end else begin
      size    = acc_size(f3);
      mis     = (a % size) != 0;
      aligned = a - (a % size);
      off     = int'(aligned % 4);
      be      = st ? 4'(((1 << size) - 1) << off) : 4'hF;
      for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % size) +: 8];
`ifdef LSU_MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 0;
`endif
      if (trap) begin
        e.kind = 2; e.rd = 0; e.data = 0;
        ev_q.push_back(e);
        exp_stall = 1;
      end else begin
        len = (d + 1 < TIMEOUT) ? d + 1 : TIMEOUT;
        exp_stall = 1 + len;
        b.addr = aligned & 32'hFFFF_FFFC; b.we = st; b.be = be; b.wdata = wd;
        b.d = d; b.rdata = rdata; b.len = len;
        bus_q.push_back(b);
        if (d + 1 > TIMEOUT) begin
          e.kind = 1; e.rd = 0; e.data = 0;
          ev_q.push_back(e);
        end else if (!st && rd != 5'd0) begin
          e.kind = 0; e.rd = rd; e.data = load_val(f3, off, rdata);
          ev_q.push_back(e);
        end
      end
      #1;
      cnt = 0;
      while (o_stall === 1'b1 && cnt < 400) begin
        cnt++;
        @(negedge clk);
        #1;
      end
      chk("stall_cycles", 32'(cnt), 32'(exp_stall));
      @(negedge clk);
    end
  endtask

  task automatic idle_gap(input int n);
    i_valid   = 1'b0;
    i_op_type = 1'($urandom);
    i_alu_out = $urandom;
    i_rd_num  = 5'($urandom);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin : stimulus
    int op, d;
    rst_n = 1'b0;
    i_valid = 1'b0; i_op_type = 1'b0; i_opcode = 7'd0; i_func_3 = 3'd0;
    i_alu_out = 32'd0; i_rs_2 = 32'd0; i_rd_num = 5'd0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_bus_err", 32'(o_bus_err | o_misalign), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 0, 3'b000, 32'h0000_1234, 32'd0, 5'd5, 0, 32'd0);
    issue(1, 0, 3'b000, 32'h0000_0103, 32'd0, 5'd7, 2, 32'h80FF_FFFF);
    issue(1, 0, 3'b100, 32'h0000_0103, 32'd0, 5'd8, 2, 32'h80FF_FFFF);
    issue(1, 1, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd9, 1, 32'd0);
    issue(1, 0, 3'b010, 32'h0000_0400, 32'd0, 5'd3, 255, 32'd0);
    issue(1, 0, 3'b010, 32'h0000_0404, 32'd0, 5'd3, TIMEOUT - 1, 32'hCAFE_F00D);
    issue(1, 0, 3'b010, 32'h0000_0408, 32'd0, 5'd3, TIMEOUT, 32'hCAFE_F00D);
    issue(1, 0, 3'b010, 32'h0000_0305, 32'd0, 5'd4, 0, 32'h1357_9BDF);
    issue(1, 0, 3'b101, 32'h0000_0503, 32'd0, 5'd6, 0, 32'h8765_4321);
    issue(0, 0, 3'b000, 32'hDEAD_BEEF, 32'd0, 5'd0, 0, 32'd0);

    // Reset while the request is outstanding
    i_valid = 1'b1; i_op_type = 1'b1; i_opcode = OP_LOAD; i_func_3 = 3'b010;
    i_alu_out = 32'h0000_0600; i_rd_num = 5'd10;
    begin
      bus_t b;
      b.addr = 32'h0000_0600; b.we = 0; b.be = 4'hF; b.wdata = 0; b.d = 255; b.rdata = 0; b.len = TIMEOUT;
      bus_q.push_back(b);
    end
    repeat (3) @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'd0);
    chk("midrst_stall", 32'(o_stall), 32'd0);
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(0, 0, 3'b000, 32'h0000_4321, 32'd0, 5'd11, 0, 32'd0);

    for (int n = 0; n < 250; n++) begin
      op = $urandom_range(0, 9);
      d  = ($urandom_range(0, 11) == 0) ? 255 : $urandom_range(0, 5);
      if (op < 3)
        issue(0, 0, 3'($urandom), $urandom, $urandom, 5'($urandom), 0, 32'd0);
      else
        issue(1, 1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), d, $urandom);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    idle_gap(5);
    chk("events_drained", 32'(ev_q.size()), 32'd0);
    chk("bus_drained", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
